// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, op-code type and constants.
package alu_pkg;

    localparam int ALU_WIDTH = 64;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 2'b00;
    localparam alu_op_t ALU_SUB = 2'b01;
    localparam alu_op_t ALU_AND = 2'b10;
    localparam alu_op_t ALU_XOR = 2'b11;

    // Only the arithmetic ops produce meaningful carry/overflow flags.
    function automatic logic op_has_flags(alu_op_t op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for packed {a, b, op} commands, with full/empty flags and occupancy count.
module alu_cmd_fifo #(
    parameter int DW    = 130,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DW-1:0]          wdata,
    input  logic                   pop,
    output logic [DW-1:0]          rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                count <= count + (AW+1)'(1);
            else if (do_pop && !do_push)
                count <= count - (AW+1)'(1);
        end
    end

    // NOTE: the storage array is not reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_queue.sv
// Command FIFO + issue stage feeding an external combinational ALU, with a registered result stage.
// Optional sticky carry/overflow flags are built when ALU_CMDQ_STICKY_EN is defined.
module alu_cmd_queue
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  alu_op_t                in_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output alu_op_t                alu_control,
    input  logic [WIDTH-1:0]       alu_result,
    input  logic                   alu_carry,
    input  logic                   alu_of,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_result,
    output logic                   out_carry,
    output logic                   out_of,
    output logic [$clog2(DEPTH):0] count
`ifdef ALU_CMDQ_STICKY_EN
    ,
    input  logic                   sticky_clr,
    output logic                   sticky_carry,
    output logic                   sticky_of
`endif
);

    localparam int DW = 2*WIDTH + 2;

    logic [DW-1:0]    head;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    alu_op_t          head_op;
    logic             full;
    logic             empty;
    logic             fire;
    logic             masked_carry;
    logic             masked_of;

    assign in_ready = !full;
    assign fire     = !empty && (!out_valid || out_ready);
    assign {head_a, head_b, head_op} = head;

    alu_cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .wdata ({in_a, in_b, in_op}),
        .pop   (fire),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_control = ALU_ADD;
        if (!empty) begin
            alu_a       = head_a;
            alu_b       = head_b;
            alu_control = head_op;
        end
    end

    assign masked_carry = alu_carry && op_has_flags(alu_control);
    assign masked_of    = alu_of && op_has_flags(alu_control);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_carry  <= 1'b0;
            out_of     <= 1'b0;
        end else if (fire) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_carry  <= masked_carry;
            out_of     <= masked_of;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef ALU_CMDQ_STICKY_EN
    // A set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_carry <= 1'b0;
            sticky_of    <= 1'b0;
        end else begin
            if (fire && masked_carry) sticky_carry <= 1'b1;
            else if (sticky_clr)      sticky_carry <= 1'b0;
            if (fire && masked_of)    sticky_of    <= 1'b1;
            else if (sticky_clr)      sticky_of    <= 1'b0;
        end
    end
`endif

endmodule
